// File: rtl/power_pkg.sv
// power_pkg: shared definitions for the rail sequencer.
//   PS_OFF..PS_FAULT : 3-bit state encodings
//   PS_MAX_RAILS     : largest supported NUM_RAILS
//   ps_state_t       : FSM state type built on the encodings above
//   ps_idx_width()   : width of a rail index, never less than 1 bit
package power_pkg;

  localparam int PS_MAX_RAILS = 8;

  localparam logic [2:0] PS_OFF   = 3'd0;
  localparam logic [2:0] PS_UP    = 3'd1;
  localparam logic [2:0] PS_ON    = 3'd2;
  localparam logic [2:0] PS_DOWN  = 3'd3;
  localparam logic [2:0] PS_FAULT = 3'd4;

  typedef enum logic [2:0] {
    ST_OFF   = PS_OFF,
    ST_UP    = PS_UP,
    ST_ON    = PS_ON,
    ST_DOWN  = PS_DOWN,
    ST_FAULT = PS_FAULT
  } ps_state_t;

  function automatic int ps_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/power_seq_sync.sv
// power_seq_sync: two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d     : asynchronous input bus (bits are synchronized independently)
//   q     : synchronized output, two clk of latency
module power_seq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/power_seq.sv
// power_seq: ordered rail power-up / reverse power-down sequencer.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ce_8hz     : one-cycle tick strobe used for timeouts and discharge delays
//   pwr_enable : power request level
//   pg         : asynchronous regulator power-good, bit i = rail i
//   fault_clr  : one-cycle pulse, clears a latched fault (FAULT state only)
//   rail_en    : regulator enables
//   pwr_good   : all rails up and stable
//   fault      : sticky fault flag
//   busy       : power-up or power-down sequence in progress
// Build option: POWER_SEQ_TIMEOUT_EN compiles in the power-good timeout in UP.
// Without it UP waits forever for power-good; a power-good loss in ON still
// latches a fault.
//
// state | meaning
// OFF   | all rails off, waiting for pwr_enable
// UP    | rail idx enabled, waiting for its power-good
// ON    | all rails up, watching for power-good loss or release
// DOWN  | rail idx just disabled, waiting out its discharge delay
// FAULT | all rails off, fault latched until fault_clr
module power_seq
  import power_pkg::*;
#(
  parameter int         NUM_RAILS  = 3,
  parameter logic [3:0] PG_TIMEOUT = 4'd10,
  parameter logic [2:0] OFF_DELAY  = 3'd2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce_8hz,
  input  logic                 pwr_enable,
  input  logic [NUM_RAILS-1:0] pg,
  input  logic                 fault_clr,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 pwr_good,
  output logic                 fault,
  output logic                 busy
);

  localparam int IW = ps_idx_width(NUM_RAILS);
  localparam int CW = ($bits(PG_TIMEOUT) > $bits(OFF_DELAY)) ? $bits(PG_TIMEOUT)
                                                             : $bits(OFF_DELAY);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_RAILS - 1);
  localparam logic [CW-1:0] OFF_DLY_C = CW'(OFF_DELAY);
`ifdef POWER_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] PG_TO_C   = CW'(PG_TIMEOUT);
`endif

  ps_state_t             state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, idx_inc, idx_dec;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [NUM_RAILS-1:0]  rail_en_q, rail_en_d;
  logic                  fault_q, fault_d;
  logic [NUM_RAILS-1:0]  pgs;

  power_seq_sync #(.WIDTH(NUM_RAILS)) u_pg_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pg),
    .q     (pgs)
  );

  assign idx_inc = idx_q + 1'b1;
  assign idx_dec = idx_q - 1'b1;
  // Saturating so a stalled counter never wraps back below its threshold.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      idx_q     <= '0;
      cnt_q     <= '0;
      rail_en_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rail_en_q <= rail_en_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rail_en_d = rail_en_q;
    fault_d   = fault_q;

    case (state_q)
      ST_OFF: begin
        rail_en_d = '0;
        if (pwr_enable && !fault_q) begin
          rail_en_d[0] = 1'b1;
          idx_d        = '0;
          cnt_d        = '0;
          state_d      = ST_UP;
        end
      end

      ST_UP: begin
        if (!pwr_enable) begin
          rail_en_d[idx_q] = 1'b0;
          cnt_d            = '0;
          state_d          = ST_DOWN;
        end else if (pgs[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_ON;
          end else begin
            idx_d              = idx_inc;
            rail_en_d[idx_inc] = 1'b1;
            cnt_d              = '0;
          end
        end
`ifdef POWER_SEQ_TIMEOUT_EN
        else if (ce_8hz) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= PG_TO_C) begin
            fault_d          = 1'b1;
            rail_en_d[idx_q] = 1'b0;
            cnt_d            = '0;
            state_d          = ST_DOWN;
          end
        end
`endif
      end

      ST_ON: begin
        // Power-good loss wins over a simultaneous release request.
        if (|(rail_en_q & ~pgs)) begin
          fault_d             = 1'b1;
          idx_d               = LAST_IDX;
          rail_en_d[LAST_IDX] = 1'b0;
          cnt_d               = '0;
          state_d             = ST_DOWN;
        end else if (!pwr_enable) begin
          idx_d               = LAST_IDX;
          rail_en_d[LAST_IDX] = 1'b0;
          cnt_d               = '0;
          state_d             = ST_DOWN;
        end
      end

      ST_DOWN: begin
        if (ce_8hz) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= OFF_DLY_C) begin
            cnt_d = '0;
            if (idx_q != '0) begin
              idx_d              = idx_dec;
              rail_en_d[idx_dec] = 1'b0;
            end else begin
              state_d = fault_q ? ST_FAULT : ST_OFF;
            end
          end
        end
      end

      ST_FAULT: begin
        rail_en_d = '0;
        if (fault_clr) begin
          fault_d = 1'b0;
          state_d = ST_OFF;
        end
      end

      default: begin
        rail_en_d = '0;
        state_d   = ST_OFF;
      end
    endcase
  end

  assign rail_en  = rail_en_q;
  assign fault    = fault_q;
  assign pwr_good = (state_q == ST_ON);
  assign busy     = (state_q == ST_UP) || (state_q == ST_DOWN);

endmodule

// File: tb/tb_power_seq.sv
// tb_power_seq: scoreboard bench for power_seq.
// Every change of {rail_en, pwr_good, busy, fault} is popped against a queue of
// expected values with an allowed clk distance from the previous change (or from
// the stimulus that causes it). pg follows rail_en delayed by 5 clk, minus a
// per-rail kill mask. Timeout expectations follow POWER_SEQ_TIMEOUT_EN.
module tb_power_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce_8hz = 1'b0;
  logic       pwr_enable;
  logic [2:0] pg;
  logic       fault_clr;
  logic [2:0] rail_en;
  logic       pwr_good;
  logic       fault;
  logic       busy;

  logic [4:0][2:0] pg_pipe = '0;
  logic [2:0]      pg_kill;
  int              ce_div  = 0;
  int              cyc     = 0;

  typedef struct {
    logic [5:0] val;
    int         lo;
    int         hi;
    int         tag;
  } exp_t;

  exp_t       exp_q[$];
  int         tag_ctr = 0;
  int         n_cmp   = 0;
  int         n_bad   = 0;
  int         t_ref   = 0;
  logic       mon_en  = 1'b0;
  logic [5:0] o_prev  = '0;
  logic [5:0] o_now;

  power_seq #(
    .NUM_RAILS  (3),
    .PG_TIMEOUT (4'd4),
    .OFF_DELAY  (3'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce_8hz     (ce_8hz),
    .pwr_enable (pwr_enable),
    .pg         (pg),
    .fault_clr  (fault_clr),
    .rail_en    (rail_en),
    .pwr_good   (pwr_good),
    .fault      (fault),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    ce_div = (ce_div == 9) ? 0 : ce_div + 1;
    ce_8hz = (ce_div == 0);
  end

  always @(posedge clk) pg_pipe <= {pg_pipe[3:0], rail_en};
  assign pg    = pg_pipe[4] & ~pg_kill;
  assign o_now = {rail_en, pwr_good, busy, fault};

  // Monitor: one comparison per observed output change.
  always @(negedge clk) begin
    if (mon_en && (o_now !== o_prev)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change: got %b at cyc %0d, required no change", o_now, cyc);
      end else begin
        exp_t e;
        int   d;
        e = exp_q.pop_front();
        d = cyc - t_ref;
        if ((o_now !== e.val) || (d < e.lo) || (d > e.hi)) begin
          n_bad++;
          $display("FAIL evt%0d: got %b after %0d clk, required %b after %0d..%0d clk",
                   e.tag, o_now, d, e.val, e.lo, e.hi);
        end
      end
      o_prev = o_now;
      t_ref  = cyc;
    end
  end

  function automatic void expect_evt(input logic [5:0] v, input int lo, input int hi);
    exp_t e;
    e.val = v;
    e.lo  = lo;
    e.hi  = hi;
    e.tag = tag_ctr;
    tag_ctr++;
    exp_q.push_back(e);
  endfunction

  task automatic check_now(input int id, input logic [5:0] req);
    n_cmp++;
    if (o_now !== req) begin
      n_bad++;
      $display("FAIL snap%0d: got %b, required %b", id, o_now, req);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d events pending after %0d clk, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Outputs encoded as {rail_en[2:0], pwr_good, busy, fault}.
  task automatic power_up();
    expect_evt(6'b001_0_1_0, 1, 1);
    expect_evt(6'b011_0_1_0, 8, 8);
    expect_evt(6'b111_0_1_0, 8, 8);
    expect_evt(6'b111_1_0_0, 8, 8);
    pwr_enable = 1'b1;
    t_ref = cyc;
    wait_drain(100);
  endtask

  task automatic power_down();
    expect_evt(6'b011_0_1_0, 1, 1);
    expect_evt(6'b001_0_1_0, 10, 20);
    expect_evt(6'b000_0_1_0, 10, 20);
    expect_evt(6'b000_0_0_0, 10, 20);
    pwr_enable = 1'b0;
    t_ref = cyc;
    wait_drain(100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    pwr_enable = 1'b0;
    fault_clr  = 1'b0;
    pg_kill    = 3'b000;
    repeat (3) @(negedge clk);
    check_now(1, 6'b000_0_0_0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_now(2, 6'b000_0_0_0);
    o_prev = o_now;
    t_ref  = cyc;
    mon_en = 1'b1;

    // Normal power-up and release.
    power_up();
    power_down();
    check_now(3, 6'b000_0_0_0);

    // Rail 1 never reports power-good.
    pg_kill = 3'b010;
`ifdef POWER_SEQ_TIMEOUT_EN
    expect_evt(6'b001_0_1_0, 1, 1);
    expect_evt(6'b011_0_1_0, 8, 8);
    expect_evt(6'b001_0_1_1, 30, 40);
    expect_evt(6'b000_0_1_1, 10, 20);
    expect_evt(6'b000_0_0_1, 10, 20);
    pwr_enable = 1'b1;
    t_ref = cyc;
    wait_drain(200);
    pwr_enable = 1'b0;
    repeat (5) @(negedge clk);
    check_now(4, 6'b000_0_0_1);
    expect_evt(6'b000_0_0_0, 1, 1);
    fault_clr = 1'b1;
    t_ref = cyc;
    @(negedge clk);
    fault_clr = 1'b0;
    wait_drain(20);
`else
    expect_evt(6'b001_0_1_0, 1, 1);
    expect_evt(6'b011_0_1_0, 8, 8);
    pwr_enable = 1'b1;
    t_ref = cyc;
    wait_drain(50);
    repeat (500) @(negedge clk);
    check_now(4, 6'b011_0_1_0);
    expect_evt(6'b001_0_1_0, 1, 1);
    expect_evt(6'b000_0_1_0, 10, 20);
    expect_evt(6'b000_0_0_0, 10, 20);
    pwr_enable = 1'b0;
    t_ref = cyc;
    wait_drain(100);
`endif
    pg_kill = 3'b000;
    repeat (20) @(negedge clk);

    // Power-good loss on rail 2 while ON, enable held high.
    power_up();
    expect_evt(6'b011_0_1_1, 3, 3);
    expect_evt(6'b001_0_1_1, 10, 20);
    expect_evt(6'b000_0_1_1, 10, 20);
    expect_evt(6'b000_0_0_1, 10, 20);
    pg_kill = 3'b100;
    t_ref = cyc;
    wait_drain(100);
    repeat (50) @(negedge clk);
    check_now(5, 6'b000_0_0_1);
    pg_kill = 3'b000;
    expect_evt(6'b000_0_0_0, 1, 1);
    expect_evt(6'b001_0_1_0, 1, 1);
    expect_evt(6'b011_0_1_0, 8, 8);
    expect_evt(6'b111_0_1_0, 8, 8);
    expect_evt(6'b111_1_0_0, 8, 8);
    fault_clr = 1'b1;
    t_ref = cyc;
    @(negedge clk);
    fault_clr = 1'b0;
    wait_drain(100);
    power_down();

    // Abort at rail 1, then re-request while still discharging.
    expect_evt(6'b001_0_1_0, 1, 1);
    expect_evt(6'b011_0_1_0, 8, 8);
    pwr_enable = 1'b1;
    t_ref = cyc;
    wait_drain(50);
    expect_evt(6'b001_0_1_0, 1, 1);
    pwr_enable = 1'b0;
    t_ref = cyc;
    wait_drain(10);
    expect_evt(6'b000_0_1_0, 10, 20);
    expect_evt(6'b000_0_0_0, 10, 20);
    expect_evt(6'b001_0_1_0, 1, 1);
    expect_evt(6'b011_0_1_0, 8, 8);
    expect_evt(6'b111_0_1_0, 8, 8);
    expect_evt(6'b111_1_0_0, 8, 8);
    pwr_enable = 1'b1;
    wait_drain(150);

    // Reset while ON drops every enable without waiting for a clock.
    expect_evt(6'b000_0_0_0, 1, 1);
    t_ref = cyc;
    #3;
    rst_n = 1'b0;
    #1;
    check_now(6, 6'b000_0_0_0);
    pwr_enable = 1'b0;
    wait_drain(10);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_now(7, 6'b000_0_0_0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
